mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_ctrl_if.sv | 30 +++
 rtl/mem_stage_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Multi-cycle data-memory port between the memory-stage controller and the memory.
// The controller holds mem_req until a single-cycle mem_done returns.
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_done
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_done
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs one data-memory access per load/store, stalls the
// front of the pipeline meanwhile, and halts on createdump, misalignment or timeout.
//
//   state | meaning
//   IDLE  | pass-through; a load/store captures its operands and starts an access
//   BUSY  | mem_req held with captured operands until mem_done or timeout
//   RESP  | access finished; MEM/WB captures the result, EX/MEM advances
//   HALT  | dump or error; pipeline frozen until reset
module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              createdump_is,
    input  logic              write_mem_is,
    input  logic              read_mem_is,
    input  logic              mem_to_reg_is,
    input  logic              reg_w_en_is,
    input  logic [DATA_W-1:0] data_2_is,
    input  logic [DATA_W-1:0] ALU_out_is,
    mem_stage_ctrl_if.master  mem,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data_os,
    output logic [DATA_W-1:0] ALU_out_os,
    output logic              mem_to_reg_os,
    output logic              reg_w_en_os,
    output logic              dump,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              access;

    assign access = read_mem_is | write_mem_is;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_os <= '0;
            dump       <= 1'b0;
            err        <= 1'b0;
        end else begin
            dump <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (createdump_is) begin
                        dump  <= 1'b1;
                        state <= HALT;
                    end else if (access && ALU_out_is[0]) begin
                        err   <= 1'b1;
                        state <= HALT;
                    end else if (access) begin
                        // A simultaneous read and write is treated as a write.
                        addr_q  <= ALU_out_is;
                        wdata_q <= data_2_is;
                        we_q    <= write_mem_is;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                    if (mem.mem_done) begin
                        if (!we_q) begin
                            rd_data_os <= mem.mem_rdata;
                        end
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= HALT;
                    end
                end
                RESP: begin
                    cnt   <= 8'd0;
                    state <= IDLE;
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // EX/MEM must hold the instruction through BUSY so RESP still sees it.
    always_comb begin
        stall = 1'b0;
        unique case (state)
            IDLE:    stall = createdump_is | access;
            BUSY:    stall = 1'b1;
            RESP:    stall = 1'b0;
            HALT:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign mem.mem_req   = (state == BUSY);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign ALU_out_os    = ALU_out_is;
    assign mem_to_reg_os = mem_to_reg_is;
    assign reg_w_en_os   = reg_w_en_is & ~stall;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: pass-through, load, slow store, timeout,
// misalignment, createdump and reset recovery against hand-computed values.
module tb_mem_stage_ctrl;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              createdump_is;
    logic              write_mem_is;
    logic              read_mem_is;
    logic              mem_to_reg_is;
    logic              reg_w_en_is;
    logic [DATA_W-1:0] data_2_is;
    logic [DATA_W-1:0] ALU_out_is;
    logic              stall;
    logic [DATA_W-1:0] rd_data_os;
    logic [DATA_W-1:0] ALU_out_os;
    logic              mem_to_reg_os;
    logic              reg_w_en_os;
    logic              dump;
    logic              err;

    int checks = 0;
    int errors = 0;
    int stall_cycles;
    int req_cycles;

    mem_stage_ctrl_if #(.DATA_W(DATA_W)) mif ();

    mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .createdump_is (createdump_is),
        .write_mem_is  (write_mem_is),
        .read_mem_is   (read_mem_is),
        .mem_to_reg_is (mem_to_reg_is),
        .reg_w_en_is   (reg_w_en_is),
        .data_2_is     (data_2_is),
        .ALU_out_is    (ALU_out_is),
        .mem           (mif),
        .stall         (stall),
        .rd_data_os    (rd_data_os),
        .ALU_out_os    (ALU_out_os),
        .mem_to_reg_os (mem_to_reg_os),
        .reg_w_en_os   (reg_w_en_os),
        .dump          (dump),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        createdump_is = 1'b0;
        write_mem_is  = 1'b0;
        read_mem_is   = 1'b0;
        mem_to_reg_is = 1'b0;
        reg_w_en_is   = 1'b0;
        data_2_is     = '0;
        ALU_out_is    = '0;
        mif.mem_done  = 1'b0;
        mif.mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_req",   32'(mif.mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_dump",  32'(dump), 32'd0);
        chk("rst_rdata", 32'(rd_data_os), 32'h0);
        chk("rst_addr",  32'(mif.mem_addr), 32'h0);
        chk("rst_we",    32'(mif.mem_we), 32'd0);

        // Non-memory op: zero-latency pass-through
        reg_w_en_is   = 1'b1;
        mem_to_reg_is = 1'b1;
        ALU_out_is    = 16'h1234;
        #1;
        chk("pt_stall",  32'(stall), 32'd0);
        chk("pt_alu",    32'(ALU_out_os), 32'h1234);
        chk("pt_wen",    32'(reg_w_en_os), 32'd1);
        chk("pt_m2r",    32'(mem_to_reg_os), 32'd1);
        chk("pt_req",    32'(mif.mem_req), 32'd0);

        // Load 0x0040, done in the first BUSY cycle
        tick();
        read_mem_is = 1'b1;
        ALU_out_is  = 16'h0040;
        #1;
        stall_cycles = 0;
        req_cycles   = 0;
        chk("ld_idle_stall", 32'(stall), 32'd1);
        chk("ld_idle_wen",   32'(reg_w_en_os), 32'd0);
        chk("ld_idle_req",   32'(mif.mem_req), 32'd0);
        if (stall) stall_cycles++;
        tick();
        mif.mem_done  = 1'b1;
        mif.mem_rdata = 16'hBEEF;
        #1;
        chk("ld_busy_req",   32'(mif.mem_req), 32'd1);
        chk("ld_busy_addr",  32'(mif.mem_addr), 32'h0040);
        chk("ld_busy_we",    32'(mif.mem_we), 32'd0);
        if (stall) stall_cycles++;
        if (mif.mem_req) req_cycles++;
        tick();
        mif.mem_done  = 1'b0;
        mif.mem_rdata = '0;
        #1;
        chk("ld_resp_stall", 32'(stall), 32'd0);
        chk("ld_resp_req",   32'(mif.mem_req), 32'd0);
        chk("ld_resp_rdata", 32'(rd_data_os), 32'hBEEF);
        chk("ld_resp_wen",   32'(reg_w_en_os), 32'd1);
        chk("ld_stall_cnt",  32'(stall_cycles), 32'd2);
        chk("ld_req_cnt",    32'(req_cycles), 32'd1);
        tick();
        read_mem_is = 1'b0;
        #1;
        chk("ld_after_stall", 32'(stall), 32'd0);
        chk("ld_after_req",   32'(mif.mem_req), 32'd0);

        // Store 0x5A5A to 0x0010, done on the 4th BUSY cycle
        write_mem_is = 1'b1;
        data_2_is    = 16'h5A5A;
        ALU_out_is   = 16'h0010;
        #1;
        stall_cycles = 0;
        req_cycles   = 0;
        if (stall) stall_cycles++;
        for (int i = 0; i < 4; i++) begin
            tick();
            mif.mem_done  = (i == 3);
            mif.mem_rdata = 16'hFFFF;
            #1;
            chk("st_busy_we",    32'(mif.mem_we), 32'd1);
            chk("st_busy_wdata", 32'(mif.mem_wdata), 32'h5A5A);
            chk("st_busy_addr",  32'(mif.mem_addr), 32'h0010);
            if (stall) stall_cycles++;
            if (mif.mem_req) req_cycles++;
        end
        tick();
        mif.mem_done = 1'b0;
        #1;
        chk("st_resp_stall", 32'(stall), 32'd0);
        chk("st_resp_req",   32'(mif.mem_req), 32'd0);
        chk("st_rdata_keep", 32'(rd_data_os), 32'hBEEF);
        chk("st_stall_cnt",  32'(stall_cycles), 32'd5);
        chk("st_req_cnt",    32'(req_cycles), 32'd4);
        tick();
        clear_inputs();
        #1;
        chk("st_after_stall", 32'(stall), 32'd0);

        // Reset in the middle of BUSY drops mem_req; a late done is ignored
        read_mem_is = 1'b1;
        ALU_out_is  = 16'h0030;
        tick();
        clear_inputs();
        #1;
        chk("mid_busy_req", 32'(mif.mem_req), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_req",   32'(mif.mem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        mif.mem_done  = 1'b1;
        mif.mem_rdata = 16'h7777;
        tick();
        mif.mem_done = 1'b0;
        #1;
        chk("mid_late_done", 32'(rd_data_os), 32'h0);
        chk("mid_late_req",  32'(mif.mem_req), 32'd0);

        // Timeout: load with no mem_done ever
        read_mem_is = 1'b1;
        ALU_out_is  = 16'h0020;
        req_cycles  = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (mif.mem_req) req_cycles++;
            chk("to_busy_err", 32'(err), 32'd0);
        end
        chk("to_req_cnt", 32'(req_cycles), 32'd15);
        tick();
        #1;
        chk("to_err",   32'(err), 32'd1);
        chk("to_stall", 32'(stall), 32'd1);
        chk("to_req",   32'(mif.mem_req), 32'd0);
        mif.mem_done  = 1'b1;
        mif.mem_rdata = 16'h1111;
        tick();
        mif.mem_done = 1'b0;
        tick();
        chk("to_halt_req",   32'(mif.mem_req), 32'd0);
        chk("to_halt_stall", 32'(stall), 32'd1);
        chk("to_halt_rdata", 32'(rd_data_os), 32'h0);
        chk("to_halt_wen",   32'(reg_w_en_os), 32'd0);
        clear_inputs();
        do_reset();
        chk("to_rst_err",   32'(err), 32'd0);
        chk("to_rst_stall", 32'(stall), 32'd0);

        // Misaligned load
        read_mem_is = 1'b1;
        ALU_out_is  = 16'h0041;
        req_cycles  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mif.mem_req) req_cycles++;
            chk("mis_err",   32'(err), 32'd1);
            chk("mis_stall", 32'(stall), 32'd1);
        end
        chk("mis_req_cnt", 32'(req_cycles), 32'd0);
        clear_inputs();
        do_reset();

        // createdump with a load pending
        createdump_is = 1'b1;
        read_mem_is   = 1'b1;
        ALU_out_is    = 16'h0040;
        #1;
        chk("cd_pre_dump", 32'(dump), 32'd0);
        tick();
        chk("cd_dump_hi", 32'(dump), 32'd1);
        chk("cd_req",     32'(mif.mem_req), 32'd0);
        chk("cd_stall",   32'(stall), 32'd1);
        chk("cd_err",     32'(err), 32'd0);
        tick();
        chk("cd_dump_lo", 32'(dump), 32'd0);
        chk("cd_req2",    32'(mif.mem_req), 32'd0);
        chk("cd_stall2",  32'(stall), 32'd1);
        tick();
        chk("cd_dump_lo2", 32'(dump), 32'd0);
        clear_inputs();
        do_reset();
        chk("cd_rst_err",   32'(err), 32'd0);
        chk("cd_rst_stall", 32'(stall), 32'd0);
        chk("cd_rst_dump",  32'(dump), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
